// File: rtl/johnson_pkg.sv
// Shared types and width helpers for the Johnson-counter stream monitor.
// Every width is derived from N or LOCK_COUNT, so they are defined here once.
package johnson_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } jsm_state_t;

    // Width of the phase index over one full period of 2N samples, at least 1.
    function automatic int phase_width(input int n);
        int w;
        w = $clog2(2 * n);
        return (w < 1) ? 1 : w;
    endfunction

    // Width of a run-length counter that must be able to hold N.
    function automatic int run_len_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Width of the good half-period counter, which saturates at LOCK_COUNT.
    function automatic int good_cnt_width(input int lock_count);
        int w;
        w = $clog2(lock_count + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/johnson_stream_monitor_edge_detect.sv
// Registers the previous sample of the serial stream and flags edges on it.
// The previous sample resets to 0, so a stream that starts high yields a rise.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic edge_any,
    output logic edge_rise
);

    logic r_d_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_q <= 1'b0;
        end else begin
            r_d_q <= d_in;
        end
    end

    assign edge_any  = d_in ^ r_d_q;
    assign edge_rise = d_in & ~r_d_q;

endmodule

// File: rtl/johnson_stream_monitor.sv
// Validates a twisted-ring-counter square wave (N low, N high), locks after
// LOCK_COUNT good half-periods, then reports a phase index within the period.
module johnson_stream_monitor
    import johnson_pkg::*;
#(
    parameter int  NUMBER_OF_FLOPS = 3,
    parameter int  LOCK_COUNT      = 2,
    localparam int PW              = phase_width(NUMBER_OF_FLOPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          d_in,
    output logic [PW-1:0] phase,
    output logic          phase_valid,
    output logic          rise_pulse,
    output logic          locked,
    output logic          err
);

    localparam int RW = run_len_width(NUMBER_OF_FLOPS);
    localparam int GW = good_cnt_width(LOCK_COUNT);

    localparam logic [RW-1:0] RL_ONE  = RW'(1);
    localparam logic [RW-1:0] RL_N    = RW'(NUMBER_OF_FLOPS);
    localparam logic [GW-1:0] GC_ONE  = GW'(1);
    localparam logic [GW-1:0] GC_LOCK = GW'(LOCK_COUNT);
    localparam logic [PW-1:0] PH_ONE  = PW'(1);
    localparam logic [PW-1:0] PH_N    = PW'(NUMBER_OF_FLOPS);
    localparam logic [PW-1:0] PH_LAST = PW'(2 * NUMBER_OF_FLOPS - 1);

    logic w_edge_any;
    logic w_edge_rise;

    edge_detect u_edge_detect (
        .clk       (clk),
        .rst       (rst),
        .d_in      (d_in),
        .edge_any  (w_edge_any),
        .edge_rise (w_edge_rise)
    );

    jsm_state_t    r_state,    w_state_nxt;
    logic [RW-1:0] r_run_len,  w_run_len_nxt;
    logic [GW-1:0] r_good_cnt, w_good_cnt_nxt;
    logic [PW-1:0] r_phase,    w_phase_nxt;
    logic          r_locked,   w_locked_nxt;
    logic          r_err,      w_err_nxt;
    logic          r_rise,     w_rise_nxt;

    logic [GW-1:0] w_good_inc;
    logic [PW-1:0] w_phase_adv;
    logic          w_edge_on_time;

    assign w_good_inc  = (r_good_cnt == GC_LOCK) ? r_good_cnt : r_good_cnt + GC_ONE;
    assign w_phase_adv = (r_phase == PH_LAST) ? '0 : r_phase + PH_ONE;

    // While locked, a rise belongs at phase 0 and a fall at phase N.
    assign w_edge_on_time = (w_phase_adv == '0   &&  w_edge_rise) ||
                            (w_phase_adv == PH_N && !w_edge_rise);

    // NOTE: every next-state signal gets a default before the case statement,
    // so no path through this block can infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_run_len_nxt  = r_run_len;
        w_good_cnt_nxt = r_good_cnt;
        w_phase_nxt    = r_phase;
        w_locked_nxt   = r_locked;
        w_err_nxt      = 1'b0;
        w_rise_nxt     = 1'b0;

        case (r_state)
            SEARCH: begin
                if (w_edge_any) begin
                    w_state_nxt    = MEASURE;
                    w_run_len_nxt  = RL_ONE;
                    w_good_cnt_nxt = '0;
                end
            end

            MEASURE: begin
                if (!w_edge_any) begin
                    if (r_run_len == RL_N) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = SEARCH;
                    end else begin
                        w_run_len_nxt = r_run_len + RL_ONE;
                    end
                end else if (r_run_len != RL_N) begin
                    w_err_nxt      = 1'b1;
                    w_good_cnt_nxt = '0;
                    w_run_len_nxt  = RL_ONE;
                end else begin
                    w_run_len_nxt  = RL_ONE;
                    w_good_cnt_nxt = w_good_inc;
                    if (w_good_inc == GC_LOCK) begin
                        w_state_nxt  = LOCKED;
                        w_locked_nxt = 1'b1;
                        w_phase_nxt  = w_edge_rise ? '0 : PH_N;
                        w_rise_nxt   = w_edge_rise;
                    end
                end
            end

            LOCKED: begin
                if (w_edge_any) begin
                    if (w_edge_on_time) begin
                        w_run_len_nxt = RL_ONE;
                        w_phase_nxt   = w_phase_adv;
                        w_rise_nxt    = (w_phase_adv == '0);
                    end else begin
                        w_err_nxt      = 1'b1;
                        w_locked_nxt   = 1'b0;
                        w_good_cnt_nxt = '0;
                        w_run_len_nxt  = RL_ONE;
                        w_phase_nxt    = '0;
                        w_state_nxt    = MEASURE;
                    end
                end else if (r_run_len == RL_N) begin
                    w_err_nxt      = 1'b1;
                    w_locked_nxt   = 1'b0;
                    w_good_cnt_nxt = '0;
                    w_phase_nxt    = '0;
                    w_state_nxt    = SEARCH;
                end else begin
                    w_run_len_nxt = r_run_len + RL_ONE;
                    w_phase_nxt   = w_phase_adv;
                end
            end

            default: begin
                w_state_nxt  = SEARCH;
                w_locked_nxt = 1'b0;
                w_phase_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= SEARCH;
            r_run_len  <= '0;
            r_good_cnt <= '0;
            r_phase    <= '0;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
            r_rise     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_run_len  <= w_run_len_nxt;
            r_good_cnt <= w_good_cnt_nxt;
            r_phase    <= w_phase_nxt;
            r_locked   <= w_locked_nxt;
            r_err      <= w_err_nxt;
            r_rise     <= w_rise_nxt;
        end
    end

    assign phase       = r_phase;
    assign phase_valid = r_locked;
    assign locked      = r_locked;
    assign rise_pulse  = r_rise;
    assign err         = r_err;

endmodule

// File: tb/tb_johnson_stream_monitor.sv
// Directed, table-driven bench for johnson_stream_monitor across three
// parameter sets: (N=3, LC=2), (N=3, LC=1) and (N=1, LC=2).
module tb_johnson_stream_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic d0  = 1'b0;
    logic d1  = 1'b0;
    logic d2  = 1'b0;

    logic [2:0] ph0, ph1;
    logic [0:0] ph2;
    logic pv0, rp0, lk0, er0;
    logic pv1, rp1, lk1, er1;
    logic pv2, rp2, lk2, er2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    johnson_stream_monitor #(.NUMBER_OF_FLOPS(3), .LOCK_COUNT(2)) u_dut0 (
        .clk(clk), .rst(rst), .d_in(d0), .phase(ph0), .phase_valid(pv0),
        .rise_pulse(rp0), .locked(lk0), .err(er0)
    );

    johnson_stream_monitor #(.NUMBER_OF_FLOPS(3), .LOCK_COUNT(1)) u_dut1 (
        .clk(clk), .rst(rst), .d_in(d1), .phase(ph1), .phase_valid(pv1),
        .rise_pulse(rp1), .locked(lk1), .err(er1)
    );

    johnson_stream_monitor #(.NUMBER_OF_FLOPS(1), .LOCK_COUNT(2)) u_dut2 (
        .clk(clk), .rst(rst), .d_in(d2), .phase(ph2), .phase_valid(pv2),
        .rise_pulse(rp2), .locked(lk2), .err(er2)
    );

    typedef struct {
        logic       d;
        logic [2:0] ph;
        logic       lk;
        logic       rp;
        logic       er;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d, expected %0d (t=%0t)", name, idx, act, exp, $time);
        end
    endtask

    task automatic row(input logic d, input int ph, input logic lk,
                       input logic rp, input logic er);
        vec_t v;
        v.d  = d;
        v.ph = 3'(ph);
        v.lk = lk;
        v.rp = rp;
        v.er = er;
        vq.push_back(v);
    endtask

    // Reads one DUT's outputs; phase is zero-extended to 3 bits.
    task automatic sample(input int which, output logic [2:0] ph, output logic pv,
                          output logic rp, output logic lk, output logic er);
        case (which)
            0:       begin ph = ph0;          pv = pv0; rp = rp0; lk = lk0; er = er0; end
            1:       begin ph = ph1;          pv = pv1; rp = rp1; lk = lk1; er = er1; end
            default: begin ph = {2'b00, ph2}; pv = pv2; rp = rp2; lk = lk2; er = er2; end
        endcase
    endtask

    task automatic check_outs(input int which, input string name, input int idx,
                              input logic [2:0] eph, input logic elk,
                              input logic erp, input logic eer);
        logic [2:0] ph;
        logic pv, rp, lk, er;
        sample(which, ph, pv, rp, lk, er);
        check({name, ".phase"},       idx, 32'(ph), 32'(eph));
        check({name, ".locked"},      idx, 32'(lk), 32'(elk));
        check({name, ".phase_valid"}, idx, 32'(pv), 32'(elk));
        check({name, ".rise_pulse"},  idx, 32'(rp), 32'(erp));
        check({name, ".err"},         idx, 32'(er), 32'(eer));
    endtask

    // Drive one sample on the falling edge, then look just after the rising edge.
    task automatic drive(input int which, input logic d);
        @(negedge clk);
        case (which)
            0:       d0 = d;
            1:       d1 = d;
            default: d2 = d;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int which, input string name, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(which, vq[i].d);
            check_outs(which, name, i, vq[i].ph, vq[i].lk, vq[i].rp, vq[i].er);
        end
    endtask

    initial begin
        // N=3, LC=2: clean lock, short low run, missing fall, lock on a fall.
        row(0,0,0,0,0); row(0,0,0,0,0); row(0,0,0,0,0); row(1,0,0,0,0);
        row(1,0,0,0,0); row(1,0,0,0,0); row(0,0,0,0,0); row(0,0,0,0,0);
        row(0,0,0,0,0); row(1,0,1,1,0); row(1,1,1,0,0); row(1,2,1,0,0);
        row(0,3,1,0,0); row(0,4,1,0,0); row(0,5,1,0,0); row(1,0,1,1,0);
        row(1,1,1,0,0); row(1,2,1,0,0); row(0,3,1,0,0); row(0,4,1,0,0);
        row(0,5,1,0,0); row(1,0,1,1,0); row(1,1,1,0,0); row(1,2,1,0,0);
        row(0,3,1,0,0); row(0,4,1,0,0); row(1,0,0,0,1); row(1,0,0,0,0);
        row(1,0,0,0,0); row(0,0,0,0,0); row(0,0,0,0,0); row(0,0,0,0,0);
        row(1,0,1,1,0); row(1,1,1,0,0); row(1,2,1,0,0); row(0,3,1,0,0);
        row(0,4,1,0,0); row(0,5,1,0,0); row(1,0,1,1,0); row(1,1,1,0,0);
        row(1,2,1,0,0); row(1,0,0,0,1); row(1,0,0,0,0); row(0,0,0,0,0);
        row(0,0,0,0,0); row(0,0,0,0,0); row(1,0,0,0,0); row(1,0,0,0,0);
        row(1,0,0,0,0); row(0,3,1,0,0); row(0,4,1,0,0); row(0,5,1,0,0);
        row(1,0,1,1,0);                                                   // 0..52
        // N=3, LC=1: lock on the first good fall at phase N, no strobe.
        row(0,0,0,0,0); row(1,0,0,0,0); row(1,0,0,0,0); row(1,0,0,0,0);
        row(0,3,1,0,0); row(0,4,1,0,0); row(0,5,1,0,0); row(1,0,1,1,0);   // 53..60
        // N=1, LC=2: toggling stream starting high.
        row(1,0,0,0,0); row(0,0,0,0,0); row(1,0,1,1,0); row(0,1,1,0,0);
        row(1,0,1,1,0); row(0,1,1,0,0);                                   // 61..66

        #12;
        check_outs(0, "rst0", 0, 3'd0, 1'b0, 1'b0, 1'b0);
        check_outs(1, "rst1", 0, 3'd0, 1'b0, 1'b0, 1'b0);
        check_outs(2, "rst2", 0, 3'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        run(0, "main", 0, 52);

        // Reset between edges while locked and strobing: outputs clear at once.
        #2;
        rst = 1'b1;
        #1;
        check_outs(0, "midrst", 0, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        d0 = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        run(0, "relock", 0, 15);

        run(1, "lc1", 53, 60);
        run(2, "n1", 61, 66);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
